branch_enable_unit: RTL
=======================

# branch_enable_unit

- Downstream consumer of the LC-3 datapath's N/Z/P condition-code register.
- Latches the branch-enable (BEN) decision from the instruction's nzp field and the current condition codes.
- Sequences the PC-load request for a taken BR through a small handshake with the control unit.
- Optionally keeps saturating counts of taken and not-taken branches for debug.

## Interface
Parameters:
- CNT_W, 16, width of each branch statistics counter

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high
- IR  input  16  current instruction register; only IR[11:9] (n,z,p mask) used
- n  input  1  negative condition code
- z  input  1  zero condition code
- p  input  1  positive condition code
- LD_BEN  input  1  load BEN register this cycle
- Br_Start  input  1  single-cycle request to resolve a branch
- Stats_Clr  input  1  synchronous clear of statistics counters
- BEN  output  1  registered branch-enable
- LD_PC_BR  output  1  one-cycle PC load strobe (PC <= PC + SEXT(offset9)) for a taken branch
- Br_Busy  output  1  high in any state other than IDLE
- Br_Done  output  1  one-cycle completion pulse
- Taken_Count  output  CNT_W  taken-branch count
- NotTaken_Count  output  CNT_W  not-taken-branch count

## Operation
BEN register:
- Reset value is 0.
- In IDLE with LD_BEN=1: BEN <= (IR[11]&n) | (IR[10]&z) | (IR[9]&p).
- LD_BEN outside IDLE is ignored and BEN holds, so a decision cannot change mid-resolution.
- LD_BEN=0: BEN holds.
- IR[11:9]=000 always yields BEN=0.
- After reset, n=z=p=0 gives BEN=0 even for IR[11:9]=111.

State machine (IDLE, EVAL, LOAD, DONE):
- IDLE:
  - Br_Start=1 -> EVAL.
  - Otherwise stay in IDLE.
- EVAL:
  - Samples registered BEN.
  - BEN=1 -> LOAD; BEN=0 -> DONE.
  - The decision is stored in an internal taken flag.
- LOAD: LD_PC_BR=1 for exactly this cycle -> DONE.
- DONE: Br_Done=1 for exactly this cycle -> IDLE.
  - On the edge leaving DONE, increment Taken_Count if taken, else NotTaken_Count.

Handshake rules:
- Br_Start outside IDLE is ignored; it is neither queued nor counted.
- Simultaneous LD_BEN and Br_Start in IDLE: BEN updates on that edge, and EVAL uses the new value.
- Outputs LD_PC_BR, Br_Busy and Br_Done are decoded from state only (Moore), so no input-to-output combinational path exists.

Counters:
- Unsigned, saturate at 2^CNT_W-1; never wrap.
- Stats_Clr has priority over an increment on the same edge; the count is lost.
- Stats_Clr is legal in any state.

Reset:
- Asynchronous reset at any time, including mid-resolution, forces IDLE.
- All outputs go to 0: BEN=0, LD_PC_BR=0, Br_Busy=0, Br_Done=0, both counters 0.
- A branch in flight is abandoned: no PC load and no count.

## Timing
- Br_Start sampled high at edge k: EVAL during cycle k..k+1, Br_Busy high from k.
- Taken branch:
  - LD_PC_BR high for the cycle after edge k+1.
  - Br_Done high after edge k+2.
  - Back in IDLE after edge k+3: 3-cycle resolution.
- Not-taken branch:
  - Br_Done high after edge k+1.
  - IDLE after edge k+2: 2-cycle resolution, LD_PC_BR never asserted.
- Counter increments are visible the cycle after Br_Done.
- Back-to-back: a new Br_Start is accepted in the first IDLE cycle after DONE.
- BEN is visible one cycle after the LD_BEN edge.

## Configuration
- Macro BRANCH_STATS_EN.
- Defined: Taken_Count and NotTaken_Count are implemented as described, and Stats_Clr is honoured.
- Undefined:
  - Counter registers are not built; both outputs are tied to 0.
  - Stats_Clr is ignored.
  - FSM, BEN and handshake behaviour are identical.

## Test plan
- Reset, then IR[11:9]=111, n=z=p=0, LD_BEN, Br_Start -> BEN=0, no LD_PC_BR, Br_Done two cycles after start, NotTaken_Count=1.
- n=1, IR[11:9]=100, LD_BEN and Br_Start same cycle -> BEN=1, LD_PC_BR one cycle, Br_Done next cycle, Taken_Count=1.
- During LOAD, pulse Br_Start and LD_BEN with IR[11:9]=000 -> both ignored; BEN stays 1; exactly one Br_Done.
- Assert Reset asynchronously in LOAD -> all outputs 0 immediately, no Br_Done, counters 0.
- With CNT_W=4 and BRANCH_STATS_EN defined, run 17 taken branches -> Taken_Count holds 15. Stats_Clr coinciding with DONE -> count 0.
- BRANCH_STATS_EN undefined, run 3 branches -> both counters read 0; FSM timing unchanged.

Source files
------------

// File: rtl/branch_enable_unit.sv
// LC-3 branch-enable register plus a small FSM that resolves BR instructions.
// Optional taken/not-taken statistics counters are built when BRANCH_STATS_EN is defined.
module branch_enable_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [15:0]      IR,
    input  logic             n,
    input  logic             z,
    input  logic             p,
    input  logic             LD_BEN,
    input  logic             Br_Start,
    input  logic             Stats_Clr,
    output logic             BEN,
    output logic             LD_PC_BR,
    output logic             Br_Busy,
    output logic             Br_Done,
    output logic [CNT_W-1:0] Taken_Count,
    output logic [CNT_W-1:0] NotTaken_Count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       taken;
    logic       ben_cond;

    // Only the nzp mask of IR matters here.
    logic unused_ir;
    assign unused_ir = ^{IR[15:12], IR[8:0]};

    assign ben_cond = (IR[11] & n) | (IR[10] & z) | (IR[9] & p);

    // BEN may only change while idle so a decision in flight stays stable.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BEN <= 1'b0;
        end else if ((state == IDLE) && LD_BEN) begin
            BEN <= ben_cond;
        end
    end

    // Handshake: Br_Start is a one-cycle request accepted only in IDLE (dropped
    // otherwise); Br_Busy is high from acceptance until the DONE cycle, and
    // Br_Done pulses exactly once per accepted request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Br_Start) state_nxt = EVAL;
            EVAL:    state_nxt = BEN ? LOAD : DONE;
            LOAD:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            taken <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == EVAL) begin
                taken <= BEN;
            end
        end
    end

    assign LD_PC_BR = (state == LOAD);
    assign Br_Busy  = (state != IDLE);
    assign Br_Done  = (state == DONE);

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] not_taken_cnt;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Clear wins over a same-edge increment; counts saturate rather than wrap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (Stats_Clr) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (state == DONE) begin
            if (taken) begin
                if (taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + 1'b1;
            end else begin
                if (not_taken_cnt != CNT_MAX) not_taken_cnt <= not_taken_cnt + 1'b1;
            end
        end
    end

    assign Taken_Count    = taken_cnt;
    assign NotTaken_Count = not_taken_cnt;
`else
    logic unused_stats;
    assign unused_stats   = Stats_Clr ^ taken;
    assign Taken_Count    = '0;
    assign NotTaken_Count = '0;
`endif

endmodule
